// File: rtl/apu_reglog_capture.sv
// APU register-window access logger: records 6502 accesses to 0x4000-0x401F as
// {phiDelta, reg-op} entries in a FWFT FIFO. Optional macro: APU_REGLOG_READ_VALUE_EN.
module apu_reglog_capture #(
    parameter int DEPTH_LOG2 = 5
) (
    input  logic                  PHI0,
    input  logic                  n_RES,
    input  logic                  RnW,
    input  logic [15:0]           A,
    input  logic [7:0]            D,
    input  logic                  cap_en,
    input  logic                  out_ready,
    output logic                  out_valid,
    output logic [31:0]           out_word0,
    output logic [31:0]           out_word1,
    output logic [DEPTH_LOG2:0]   level,
    output logic                  overflow,
    output logic [15:0]           drop_cnt
);

    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2-1:0] PTR_ONE   = 1;
    localparam logic [DEPTH_LOG2:0]   LEVEL_ONE = 1;

    logic [63:0]           r_mem [DEPTH];
    logic [DEPTH_LOG2-1:0] r_wr_ptr;
    logic [DEPTH_LOG2-1:0] r_rd_ptr;
    logic [DEPTH_LOG2:0]   r_level;
    logic [31:0]           r_dcnt;
    logic                  r_overflow;
    logic [15:0]           r_drop_cnt;

    logic                  w_hit;
    logic                  w_empty;
    logic                  w_full;
    logic                  w_pop;
    logic                  w_capture;
    logic                  w_push;
    logic                  w_drop;
    logic [31:0]           w_dcnt_inc;
    logic [7:0]            w_value;
    logic [63:0]           w_entry;
    logic [63:0]           w_head;

    assign w_hit     = (A[15:5] == 11'h200);
    assign w_empty   = (r_level == '0);
    // Level never exceeds DEPTH, so its extra MSB is set exactly when full.
    assign w_full    = r_level[DEPTH_LOG2];
    assign w_pop     = !w_empty && out_ready;
    assign w_capture = w_hit && cap_en;
    assign w_push    = w_capture && (!w_full || w_pop);
    assign w_drop    = w_capture && w_full && !w_pop;

    assign w_dcnt_inc = (&r_dcnt) ? r_dcnt : r_dcnt + 32'd1;

`ifdef APU_REGLOG_READ_VALUE_EN
    assign w_value = D;
`else
    assign w_value = RnW ? 8'h00 : D;
`endif

    assign w_entry = {w_dcnt_inc, 16'h0000, w_value, RnW, 2'b00, A[4:0]};

    // Delta counter restarts on every register access, captured or not.
    always_ff @(negedge PHI0 or negedge n_RES) begin
        if (!n_RES) begin
            r_dcnt <= '0;
        end else if (w_hit) begin
            r_dcnt <= '0;
        end else begin
            r_dcnt <= w_dcnt_inc;
        end
    end

    // NOTE: the storage array has no reset; emptiness is tracked by r_level and
    // the outputs are forced to zero when empty, so stale contents are never seen.
    always_ff @(negedge PHI0) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= w_entry;
        end
    end

    always_ff @(negedge PHI0 or negedge n_RES) begin
        if (!n_RES) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_ONE;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_ONE;
            end
            case ({w_push, w_pop})
                2'b10:   r_level <= r_level + LEVEL_ONE;
                2'b01:   r_level <= r_level - LEVEL_ONE;
                default: r_level <= r_level;
            endcase
        end
    end

    always_ff @(negedge PHI0 or negedge n_RES) begin
        if (!n_RES) begin
            r_overflow <= 1'b0;
            r_drop_cnt <= '0;
        end else if (w_drop) begin
            r_overflow <= 1'b1;
            if (r_drop_cnt != 16'hFFFF) begin
                r_drop_cnt <= r_drop_cnt + 16'd1;
            end
        end
    end

    assign w_head    = w_empty ? 64'h0 : r_mem[r_rd_ptr];
    assign out_valid = !w_empty;
    assign out_word0 = w_head[63:32];
    assign out_word1 = w_head[31:0];
    assign level     = r_level;
    assign overflow  = r_overflow;
    assign drop_cnt  = r_drop_cnt;

endmodule

// File: tb/tb_apu_reglog_capture.sv
// Self-checking bench for apu_reglog_capture: directed vector table, reset
// sequence, then randomized traffic against a queue-based reference model.
module tb_apu_reglog_capture;

    localparam int DL2   = 2;
    localparam int DEPTH = 1 << DL2;
`ifdef APU_REGLOG_READ_VALUE_EN
    localparam logic [31:0] RD_W1 = 32'h0000_4195;
`else
    localparam logic [31:0] RD_W1 = 32'h0000_0095;
`endif

    logic            PHI0;
    logic            n_RES;
    logic            RnW;
    logic [15:0]     A;
    logic [7:0]      D;
    logic            cap_en;
    logic            out_ready;
    logic            out_valid;
    logic [31:0]     out_word0;
    logic [31:0]     out_word1;
    logic [DL2:0]    level;
    logic            overflow;
    logic [15:0]     drop_cnt;

    apu_reglog_capture #(.DEPTH_LOG2(DL2)) dut (
        .PHI0      (PHI0),
        .n_RES     (n_RES),
        .RnW       (RnW),
        .A         (A),
        .D         (D),
        .cap_en    (cap_en),
        .out_ready (out_ready),
        .out_valid (out_valid),
        .out_word0 (out_word0),
        .out_word1 (out_word1),
        .level     (level),
        .overflow  (overflow),
        .drop_cnt  (drop_cnt)
    );

    initial PHI0 = 1'b1;
    always #5 PHI0 = ~PHI0;

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic check_all(input string tag, input logic ev, input logic [31:0] ew0,
                             input logic [31:0] ew1, input logic [DL2:0] elvl,
                             input logic eovf, input logic [15:0] edrop);
        check({tag, ".valid"},    64'(out_valid), 64'(ev));
        check({tag, ".word0"},    64'(out_word0), 64'(ew0));
        check({tag, ".word1"},    64'(out_word1), 64'(ew1));
        check({tag, ".level"},    64'(level),     64'(elvl));
        check({tag, ".overflow"}, 64'(overflow),  64'(eovf));
        check({tag, ".drop_cnt"}, 64'(drop_cnt),  64'(edrop));
    endtask

    task automatic step();
        @(negedge PHI0);
        #1;
    endtask

    task automatic drive(input logic rnw, input logic [15:0] a, input logic [7:0] d,
                         input logic cap, input logic rdy);
        RnW = rnw; A = a; D = d; cap_en = cap; out_ready = rdy;
    endtask

    // Reference model: queue of {delta, op} entries built from the access rules.
    logic [63:0]     m_q[$];
    longint unsigned m_dcnt;
    logic            m_ovf;
    int              m_drop;

    task automatic model_reset();
        m_q.delete();
        m_dcnt = 0;
        m_ovf  = 1'b0;
        m_drop = 0;
    endtask

    task automatic model_edge();
        longint unsigned sat_max = 64'hFFFF_FFFF;
        longint unsigned next_d;
        bit              in_window;
        bit              popping;
        logic [7:0]      val;
        next_d    = (m_dcnt + 1 > sat_max) ? sat_max : m_dcnt + 1;
        in_window = (A >= 16'h4000) && (A <= 16'h401F);
        popping   = (m_q.size() > 0) && out_ready;
        if (popping) void'(m_q.pop_front());
        if (in_window) begin
            if (cap_en) begin
`ifdef APU_REGLOG_READ_VALUE_EN
                val = D;
`else
                val = RnW ? 8'h00 : D;
`endif
                if (m_q.size() < DEPTH) begin
                    m_q.push_back({32'(next_d), 16'h0, val, RnW, 2'b00, 5'(A - 16'h4000)});
                end else begin
                    m_ovf = 1'b1;
                    if (m_drop < 65535) m_drop++;
                end
            end
            m_dcnt = 0;
        end else begin
            m_dcnt = next_d;
        end
    endtask

    task automatic check_model(input string tag);
        logic [63:0] head;
        head = (m_q.size() > 0) ? m_q[0] : 64'h0;
        check_all(tag, m_q.size() > 0, head[63:32], head[31:0], (DL2+1)'(m_q.size()),
                  m_ovf, 16'(m_drop));
    endtask

    typedef struct {
        int           n;
        logic         rnw;
        logic [15:0]  a;
        logic [7:0]   d;
        logic         cap;
        logic         rdy;
        logic         ev;
        logic [31:0]  ew0;
        logic [31:0]  ew1;
        logic [DL2:0] elvl;
        logic         eovf;
        logic [15:0]  edrop;
    } vec_t;

    vec_t tbl[18];

    initial begin
        tbl[0]  = '{10, 1'b1, 16'h0000, 8'h00, 1'b1, 1'b0, 1'b0,  0, 32'h0,    3'd0, 1'b0, 16'd0};
        tbl[1]  = '{1,  1'b0, 16'h4015, 8'h0F, 1'b1, 1'b0, 1'b1, 11, 32'h0F15, 3'd1, 1'b0, 16'd0};
        tbl[2]  = '{1,  1'b1, 16'h4015, 8'h41, 1'b1, 1'b0, 1'b1, 11, 32'h0F15, 3'd2, 1'b0, 16'd0};
        tbl[3]  = '{1,  1'b1, 16'h4015, 8'h41, 1'b1, 1'b0, 1'b1, 11, 32'h0F15, 3'd3, 1'b0, 16'd0};
        tbl[4]  = '{1,  1'b1, 16'h0000, 8'h00, 1'b1, 1'b1, 1'b1,  1, RD_W1,    3'd2, 1'b0, 16'd0};
        tbl[5]  = '{1,  1'b1, 16'h0000, 8'h00, 1'b1, 1'b1, 1'b1,  1, RD_W1,    3'd1, 1'b0, 16'd0};
        tbl[6]  = '{1,  1'b0, 16'h3FFF, 8'h5A, 1'b1, 1'b1, 1'b0,  0, 32'h0,    3'd0, 1'b0, 16'd0};
        tbl[7]  = '{1,  1'b1, 16'h4020, 8'h00, 1'b1, 1'b0, 1'b0,  0, 32'h0,    3'd0, 1'b0, 16'd0};
        tbl[8]  = '{1,  1'b1, 16'h0000, 8'h00, 1'b1, 1'b0, 1'b0,  0, 32'h0,    3'd0, 1'b0, 16'd0};
        tbl[9]  = '{1,  1'b0, 16'h4000, 8'hAA, 1'b1, 1'b0, 1'b1,  6, 32'hAA00, 3'd1, 1'b0, 16'd0};
        tbl[10] = '{1,  1'b0, 16'h401F, 8'h12, 1'b0, 1'b0, 1'b1,  6, 32'hAA00, 3'd1, 1'b0, 16'd0};
        tbl[11] = '{1,  1'b0, 16'h4001, 8'h33, 1'b1, 1'b0, 1'b1,  6, 32'hAA00, 3'd2, 1'b0, 16'd0};
        tbl[12] = '{4,  1'b0, 16'h4002, 8'h55, 1'b1, 1'b0, 1'b1,  6, 32'hAA00, 3'd4, 1'b1, 16'd2};
        tbl[13] = '{1,  1'b0, 16'h4003, 8'h66, 1'b1, 1'b1, 1'b1,  1, 32'h3301, 3'd4, 1'b1, 16'd2};
        tbl[14] = '{1,  1'b1, 16'h0000, 8'h00, 1'b1, 1'b1, 1'b1,  1, 32'h5502, 3'd3, 1'b1, 16'd2};
        tbl[15] = '{1,  1'b1, 16'h0000, 8'h00, 1'b1, 1'b1, 1'b1,  1, 32'h5502, 3'd2, 1'b1, 16'd2};
        tbl[16] = '{1,  1'b1, 16'h0000, 8'h00, 1'b1, 1'b1, 1'b1,  1, 32'h6603, 3'd1, 1'b1, 16'd2};
        tbl[17] = '{1,  1'b1, 16'h0000, 8'h00, 1'b1, 1'b1, 1'b0,  0, 32'h0,    3'd0, 1'b1, 16'd2};

        n_RES = 1'b0;
        drive(1'b1, 16'h0000, 8'h00, 1'b1, 1'b0);
        repeat (2) step();
        check_all("reset", 1'b0, 32'h0, 32'h0, 3'd0, 1'b0, 16'd0);
        #2 n_RES = 1'b1;

        for (int i = 0; i < 18; i++) begin
            drive(tbl[i].rnw, tbl[i].a, tbl[i].d, tbl[i].cap, tbl[i].rdy);
            repeat (tbl[i].n) step();
            check_all($sformatf("vec%0d", i), tbl[i].ev, tbl[i].ew0, tbl[i].ew1,
                      tbl[i].elvl, tbl[i].eovf, tbl[i].edrop);
        end

        // Three queued entries, then an asynchronous reset between edges.
        drive(1'b0, 16'h4010, 8'h01, 1'b1, 1'b0);
        repeat (3) step();
        check("midrst.level_before", 64'(level), 64'd3);
        drive(1'b1, 16'h0000, 8'h00, 1'b1, 1'b0);
        #1 n_RES = 1'b0;
        #1 check_all("midrst", 1'b0, 32'h0, 32'h0, 3'd0, 1'b0, 16'd0);
        #1 n_RES = 1'b1;
        repeat (4) step();
        drive(1'b0, 16'h4008, 8'h77, 1'b1, 1'b0);
        step();
        check_all("after_rst", 1'b1, 32'd5, 32'h7708, 3'd1, 1'b0, 16'd0);

        // Randomized traffic against the reference model.
        drive(1'b1, 16'h0000, 8'h00, 1'b1, 1'b0);
        n_RES = 1'b0;
        model_reset();
        #1 n_RES = 1'b1;
        for (int c = 0; c < 3000; c++) begin
            int sel;
            sel = int'($urandom_range(0, 9));
            if (sel < 6)       A = 16'h4000 + 16'($urandom_range(0, 31));
            else if (sel == 6) A = 16'h0000;
            else if (sel == 7) A = ($urandom_range(0, 1) == 0) ? 16'h3FFF : 16'h4020;
            else               A = 16'($urandom);
            RnW       = 1'($urandom);
            D         = 8'($urandom);
            cap_en    = ($urandom_range(0, 7) != 0);
            out_ready = ((c / 64) % 2 == 0) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
            step();
            model_edge();
            check_model($sformatf("rand%0d", c));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
